br_resolve_unit: RTL and testbench

Branch resolution and predictor-update controller sitting at the EX/BRU boundary. It compares each resolved control-transfer outcome against the prediction carried down the pipeline from fetch and drives the predictor's update port inside `next_pc_unit` with a registered pulse. On a misprediction it raises a flush and redirect PC for the front end, holding them until fetch acknowledges. It also keeps saturating branch and misprediction counters for performance monitoring.

---
 rtl/br_resolve_unit.sv | 156 +++++++++++++++
 tb/tb_br_resolve_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/br_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : br_resolve_unit
// Purpose  : Branch resolution and predictor-update controller at EX/BRU.
//            Compares each resolved control transfer with its fetch-time
//            prediction. Each resolution produces a one-cycle registered update
//            pulse for the predictor. A mispredict raises a flush and redirect
//            PC, which are held until fetch acknowledges. Saturating branch and
//            mispredict counters are kept for performance monitoring.
// Ports    : i_clk, i_rst            - clock, synchronous active-high reset
//            i_ex_*                  - EX-stage instruction and BRU outcome
//            i_redirect_ack          - fetch accepted the redirect
//            o_br_update_*           - predictor update port (registered)
//            o_flush, o_redirect_pc  - front-end squash and redirect (level)
//            o_br_count, o_mispred_count - saturating perf counters
// Revision : 1.0 - initial release
// ============================================================================
module br_resolve_unit #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ex_valid,
    input  logic             i_ex_stall,
    input  logic             i_ex_is_br,
    input  logic             i_ex_is_jal,
    input  logic             i_ex_is_jalr,
    input  logic [31:0]      i_ex_pc,
    input  logic             i_ex_taken,
    input  logic [31:0]      i_ex_target,
    input  logic             i_ex_prd_taken,
    input  logic [31:0]      i_ex_prd_target,
    input  logic             i_redirect_ack,
    output logic             o_br_update_en,
    output logic             o_br_update_valid,
    output logic             o_br_update_taken,
    output logic             o_br_update_already_prd,
    output logic [31:0]      o_br_update_pc,
    output logic [31:0]      o_br_update_target,
    output logic             o_flush,
    output logic [31:0]      o_redirect_pc,
    output logic [CNT_W-1:0] o_br_count,
    output logic [CNT_W-1:0] o_mispred_count
);

    typedef enum logic [0:0] {
        S_RUN      = 1'b0,
        S_REDIRECT = 1'b1
    } state_t;

    localparam logic [31:0] c_INSN_BYTES = 32'd4;

    state_t           state_q;
    logic             upd_en_q;
    logic             upd_valid_q;
    logic             upd_taken_q;
    logic             upd_aprd_q;
    logic [31:0]      upd_pc_q;
    logic [31:0]      upd_target_q;
    logic             flush_q;
    logic [31:0]      redirect_pc_q;
    logic [CNT_W-1:0] br_count_q;
    logic [CNT_W-1:0] br_count_d;
    logic [CNT_W-1:0] mispred_count_q;
    logic [CNT_W-1:0] mispred_count_d;

    logic             w_resolve;
    logic             w_mispred;
    logic [31:0]      w_next_pc;

    // Wrong-path instructions in REDIRECT never resolve; a stalled
    // instruction only resolves on the cycle it leaves EX.
    assign w_resolve = (state_q == S_RUN) && i_ex_valid && !i_ex_stall &&
                       (i_ex_is_br || i_ex_is_jal || i_ex_is_jalr);

    // A correctly predicted not-taken branch ignores the target compare.
    assign w_mispred = (i_ex_taken != i_ex_prd_taken) ||
                       (i_ex_taken && (i_ex_target != i_ex_prd_target));

    assign w_next_pc = i_ex_taken ? i_ex_target : (i_ex_pc + c_INSN_BYTES);

    // Saturating increments: hold at all-ones instead of wrapping.
    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (!(&br_count_q)) begin
            br_count_d = br_count_q + CNT_W'(1);
        end
        if (!(&mispred_count_q)) begin
            mispred_count_d = mispred_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= S_RUN;
            upd_en_q        <= 1'b0;
            upd_valid_q     <= 1'b0;
            upd_taken_q     <= 1'b0;
            upd_aprd_q      <= 1'b0;
            upd_pc_q        <= 32'd0;
            upd_target_q    <= 32'd0;
            flush_q         <= 1'b0;
            redirect_pc_q   <= 32'd0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            upd_en_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (w_resolve) begin
                        upd_en_q     <= 1'b1;
                        // Indirect targets are not stored in the predictor.
                        upd_valid_q  <= !i_ex_is_jalr;
                        upd_taken_q  <= i_ex_taken;
                        upd_aprd_q   <= i_ex_prd_taken;
                        upd_pc_q     <= i_ex_pc;
                        upd_target_q <= i_ex_target;
                        br_count_q   <= br_count_d;
                        if (w_mispred) begin
                            flush_q         <= 1'b1;
                            redirect_pc_q   <= w_next_pc;
                            mispred_count_q <= mispred_count_d;
                            state_q         <= S_REDIRECT;
                        end
                    end
                end
                S_REDIRECT: begin
                    // Redirect PC is left untouched so it stays stable
                    // for the whole flush window.
                    if (i_redirect_ack) begin
                        flush_q <= 1'b0;
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    state_q <= S_RUN;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_br_update_en          = upd_en_q;
    assign o_br_update_valid       = upd_valid_q;
    assign o_br_update_taken       = upd_taken_q;
    assign o_br_update_already_prd = upd_aprd_q;
    assign o_br_update_pc          = upd_pc_q;
    assign o_br_update_target      = upd_target_q;
    assign o_flush                 = flush_q;
    assign o_redirect_pc           = redirect_pc_q;
    assign o_br_count              = br_count_q;
    assign o_mispred_count         = mispred_count_q;

endmodule
`default_nettype wire

// File: tb/tb_br_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_br_resolve_unit
// Purpose  : Self-checking bench for br_resolve_unit. Directed steps from
//            the test plan followed by randomized traffic, all compared
//            each cycle against a behavioural model of the resolve rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_br_resolve_unit;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid, ex_stall, is_br, is_jal, is_jalr;
    logic [31:0]       ex_pc, ex_target, prd_target;
    logic              ex_taken, prd_taken, ack;
    logic              upd_en, upd_valid, upd_taken, upd_aprd, flush;
    logic [31:0]       upd_pc, upd_target, redirect_pc;
    logic [CNT_W-1:0]  br_count, mispred_count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit          m_redir;
    bit          m_en, m_valid, m_taken, m_aprd, m_flush;
    logic [31:0] m_pc, m_tgt, m_rpc;
    int          m_brc, m_mis;

    always #5 clk = ~clk;

    br_resolve_unit #(.CNT_W(CNT_W)) dut (
        .i_clk                   (clk),
        .i_rst                   (rst),
        .i_ex_valid              (ex_valid),
        .i_ex_stall              (ex_stall),
        .i_ex_is_br              (is_br),
        .i_ex_is_jal             (is_jal),
        .i_ex_is_jalr            (is_jalr),
        .i_ex_pc                 (ex_pc),
        .i_ex_taken              (ex_taken),
        .i_ex_target             (ex_target),
        .i_ex_prd_taken          (prd_taken),
        .i_ex_prd_target         (prd_target),
        .i_redirect_ack          (ack),
        .o_br_update_en          (upd_en),
        .o_br_update_valid       (upd_valid),
        .o_br_update_taken       (upd_taken),
        .o_br_update_already_prd (upd_aprd),
        .o_br_update_pc          (upd_pc),
        .o_br_update_target      (upd_target),
        .o_flush                 (flush),
        .o_redirect_pc           (redirect_pc),
        .o_br_count              (br_count),
        .o_mispred_count         (mispred_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("upd_en", {31'd0, upd_en}, {31'd0, m_en});
        chk("flush", {31'd0, flush}, {31'd0, m_flush});
        chk("br_count", 32'(br_count), 32'(m_brc));
        chk("mispred_count", 32'(mispred_count), 32'(m_mis));
        chk("upd_valid", {31'd0, upd_valid}, {31'd0, m_valid});
        chk("upd_taken", {31'd0, upd_taken}, {31'd0, m_taken});
        chk("upd_aprd", {31'd0, upd_aprd}, {31'd0, m_aprd});
        chk("upd_pc", upd_pc, m_pc);
        chk("upd_target", upd_target, m_tgt);
        chk("redirect_pc", redirect_pc, m_rpc);
    endtask

    // Advance the model on the current inputs, clock once, then compare.
    task automatic cycle();
        if (rst) begin
            m_redir = 0; m_en = 0; m_valid = 0; m_taken = 0; m_aprd = 0;
            m_flush = 0; m_pc = 0; m_tgt = 0; m_rpc = 0; m_brc = 0; m_mis = 0;
        end else begin
            m_en = 0;
            if (!m_redir) begin
                if (ex_valid && !ex_stall && (is_br || is_jal || is_jalr)) begin
                    m_en    = 1;
                    m_valid = !is_jalr;
                    m_taken = ex_taken;
                    m_aprd  = prd_taken;
                    m_pc    = ex_pc;
                    m_tgt   = ex_target;
                    m_brc   = (m_brc < CNT_MAX) ? m_brc + 1 : CNT_MAX;
                    if ((ex_taken != prd_taken) || (ex_taken && ex_target != prd_target)) begin
                        m_flush = 1;
                        m_redir = 1;
                        m_rpc   = ex_taken ? ex_target : ex_pc + 32'd4;
                        m_mis   = (m_mis < CNT_MAX) ? m_mis + 1 : CNT_MAX;
                    end
                end
            end else if (ack) begin
                m_flush = 0;
                m_redir = 0;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_ex(input bit v, input bit st, input bit b, input bit j, input bit jr,
                          input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                          input bit ptk, input logic [31:0] ptg);
        ex_valid = v; ex_stall = st; is_br = b; is_jal = j; is_jalr = jr;
        ex_pc = pc; ex_taken = tk; ex_target = tg; prd_taken = ptk; prd_target = ptg;
    endtask

    task automatic idle();
        set_ex(0, 0, 0, 0, 0, 32'd0, 0, 32'd0, 0, 32'd0);
    endtask

    initial begin
        rst = 1; ack = 0;
        idle();
        cycle();
        cycle();
        rst = 0;
        // Idle after reset: everything stays zero
        cycle();
        cycle();
        chk("reset_flush_zero", {31'd0, flush}, 32'd0);

        // Correctly predicted taken branch
        set_ex(1, 0, 1, 0, 0, 32'h100, 1, 32'h140, 1, 32'h140);
        cycle();
        chk("pred_ok_target", upd_target, 32'h140);
        idle();
        cycle();
        chk("pulse_one_cycle", {31'd0, upd_en}, 32'd0);

        // Mispredicted not-taken branch, then wrong-path traffic during flush
        set_ex(1, 0, 1, 0, 0, 32'h200, 0, 32'h300, 1, 32'h300);
        cycle();
        chk("mis_redirect", redirect_pc, 32'h204);
        set_ex(1, 0, 1, 0, 0, 32'h204, 1, 32'h900, 0, 32'h0);
        cycle();
        cycle();
        cycle();
        ack = 1;
        cycle();
        ack = 0;
        idle();
        cycle();
        chk("mis_count_after_ack", 32'(mispred_count), 32'd1);

        // JALR mispredicted on target
        set_ex(1, 0, 0, 0, 1, 32'h400, 1, 32'h880, 1, 32'h800);
        cycle();
        chk("jalr_redirect", redirect_pc, 32'h880);
        idle();
        ack = 1;               // minimum-width flush
        cycle();
        ack = 0;
        cycle();

        // Stalled branch: only one update when released
        set_ex(1, 1, 1, 0, 0, 32'h500, 0, 32'h540, 0, 32'h540);
        for (int i = 0; i < 4; i++) cycle();
        ex_stall = 0;
        cycle();
        idle();
        cycle();

        // Back-to-back correct JAL + branch, then PC wrap on redirect
        set_ex(1, 0, 0, 1, 0, 32'h600, 1, 32'h700, 1, 32'h700);
        cycle();
        set_ex(1, 0, 1, 0, 0, 32'h700, 0, 32'h0, 0, 32'h0);
        cycle();
        set_ex(1, 0, 1, 0, 0, 32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10);
        cycle();
        chk("wrap_redirect", redirect_pc, 32'h0);
        idle();
        ack = 1;
        cycle();
        ack = 0;

        // Drive mispredicts until both counters saturate
        for (int i = 0; i < 20; i++) begin
            set_ex(1, 0, 1, 0, 0, 32'h1000 + 32'(i * 4), 1, 32'h2000, 0, 32'h0);
            cycle();
            idle();
            ack = 1;
            cycle();
            ack = 0;
        end
        chk("br_sat", 32'(br_count), 32'(CNT_MAX));
        chk("mis_sat", 32'(mispred_count), 32'(CNT_MAX));

        // Reset while in REDIRECT
        set_ex(1, 0, 1, 0, 0, 32'h3000, 1, 32'h3100, 0, 32'h0);
        cycle();
        idle();
        rst = 1;
        cycle();
        rst = 0;
        chk("rst_mid_flush", {31'd0, flush}, 32'd0);
        chk("rst_mid_cnt", 32'(br_count), 32'd0);
        // Back in RUN: a new event must be accepted
        set_ex(1, 0, 1, 0, 0, 32'h3200, 0, 32'h0, 0, 32'h0);
        cycle();
        chk("rst_then_run", {31'd0, upd_en}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int kind;
            logic [31:0] tg;
            kind = int'($urandom_range(0, 2));
            tg   = {$urandom_range(0, 15), 2'b00} + 32'h8000;
            ex_valid   = ($urandom_range(0, 3) != 0);
            ex_stall   = ($urandom_range(0, 3) == 0);
            is_br      = (kind == 0);
            is_jal     = (kind == 1);
            is_jalr    = (kind == 2);
            ex_pc      = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 4095), 2'b00};
            ex_taken   = (kind != 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ex_target  = tg;
            prd_taken  = ($urandom_range(0, 3) == 0) ? !ex_taken : ex_taken;
            prd_target = ($urandom_range(0, 3) == 0) ? tg + 32'd4 : tg;
            ack        = ($urandom_range(0, 2) == 0);
            rst        = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 0; ack = 0;
        idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
